// File: rtl/apb_gpio_irq.sv
// APB3 GPIO with per-pin direction, synchronised inputs and per-pin edge interrupts.
// Define GPIO_BSRR_EN to add write-only atomic set (BSR, offset 6) and clear (BRR, offset 7) of ODR.
module apb_gpio_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [4:0]        PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic              PSEL,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  input  logic [WIDTH-1:0]  inPort,
  output logic [WIDTH-1:0]  outPort,
  output logic [WIDTH-1:0]  outEn,
  output logic              irq
);

  localparam logic [2:0] ADDR_MODER = 3'd0;
  localparam logic [2:0] ADDR_IDR   = 3'd1;
  localparam logic [2:0] ADDR_ODR   = 3'd2;
  localparam logic [2:0] ADDR_IER   = 3'd3;
  localparam logic [2:0] ADDR_EDGE  = 3'd4;
  localparam logic [2:0] ADDR_ISR   = 3'd5;
`ifdef GPIO_BSRR_EN
  localparam logic [2:0] ADDR_BSR   = 3'd6;
  localparam logic [2:0] ADDR_BRR   = 3'd7;
`endif
  localparam logic [2:0] SETTLE     = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] moder, odr, odr_next, ier, edge_sel, isr;
  logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0] sync, prev, rise, fall, det, clr, idr;
  logic [2:0]       settle_cnt;
  logic             armed, access, wr_en, rd_en;
  logic [2:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign addr        = PADDR[4:2];
  assign wdata       = PWDATA[WIDTH-1:0];
  assign access      = PSEL & PENABLE & ~PREADY;
  assign wr_en       = access & PWRITE;
  assign rd_en       = access & ~PWRITE;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // One wait state: PREADY rises on the edge that commits the access and drops on the next.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      PREADY <= access;
      if (rd_en) PRDATA <= rdata;
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev <= '0;
    end else begin
      sync_ff[0] <= inPort;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev <= sync;
    end
  end

  // Hold off detection until the synchroniser and history flops contain real pin values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) settle_cnt <= '0;
    else if (settle_cnt != SETTLE) settle_cnt <= settle_cnt + 3'd1;
  end

  assign armed = (settle_cnt == SETTLE);

  always_comb begin
    rise = sync & ~prev;
    fall = ~sync & prev;
    det  = '0;
    if (armed) det = ~moder & ((~edge_sel & rise) | (edge_sel & fall));
    clr  = '0;
    if (wr_en && addr == ADDR_ISR) clr = wdata;
  end

`ifdef GPIO_BSRR_EN
  always_comb begin
    odr_next = odr;
    if (wr_en) begin
      case (addr)
        ADDR_ODR: odr_next = wdata;
        ADDR_BSR: odr_next = odr | wdata;
        ADDR_BRR: odr_next = odr & ~wdata;
        default:  odr_next = odr;
      endcase
    end
  end
`else
  always_comb begin
    odr_next = odr;
    if (wr_en && addr == ADDR_ODR) odr_next = wdata;
  end
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      moder    <= '0;
      odr      <= '0;
      ier      <= '0;
      edge_sel <= '0;
      isr      <= '0;
    end else begin
      odr <= odr_next;
      if (wr_en && addr == ADDR_MODER) moder    <= wdata;
      if (wr_en && addr == ADDR_IER)   ier      <= wdata;
      if (wr_en && addr == ADDR_EDGE)  edge_sel <= wdata;
      // A fresh edge on the clearing cycle must not be lost, so set beats clear.
      isr <= (isr & ~clr) | det;
    end
  end

  assign idr = (sync & ~moder) | (odr & moder);

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_MODER: rdata[WIDTH-1:0] = moder;
      ADDR_IDR:   rdata[WIDTH-1:0] = idr;
      ADDR_ODR:   rdata[WIDTH-1:0] = odr;
      ADDR_IER:   rdata[WIDTH-1:0] = ier;
      ADDR_EDGE:  rdata[WIDTH-1:0] = edge_sel;
      ADDR_ISR:   rdata[WIDTH-1:0] = isr;
      default:    rdata = '0;
    endcase
  end

  assign outEn   = moder;
  assign outPort = odr & moder;
  assign irq     = |(isr & ier);

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Self-checking bench for apb_gpio_irq: directed scenarios then random traffic against a
// cycle-history reference model (expects GPIO_BSRR_EN to match the DUT build).
module tb_apb_gpio_irq;

  localparam int WIDTH = 8;
  localparam int S     = 2;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [4:0]        PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic              PWRITE = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PSEL = 1'b0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic [WIDTH-1:0]  inPort = '1;
  logic [WIDTH-1:0]  outPort;
  logic [WIDTH-1:0]  outEn;
  logic              irq;

  logic              accessCycle = 1'b0;

  int errors = 0;
  int checks = 0;

  apb_gpio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(S)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .inPort  (inPort),
    .outPort (outPort),
    .outEn   (outEn),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: registers plus a per-cycle history of sampled pin values.
  // The synchronised view of the pins at edge k is the sample taken S edges earlier.
  logic [7:0]  mdlModer = '0, mdlOdr = '0, mdlIer = '0, mdlEdge = '0, mdlIsr = '0;
  logic [31:0] mdlRdata = '0;
  logic [7:0]  hist[$];
  int          cyc = 0;
  logic [7:0]  syncNow, syncPrev, setMask, clrMask;

  function automatic logic [7:0] sampleAt(input int j);
    if (j < 1) return 8'h00;
    return hist[j-1];
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mdlModer = '0; mdlOdr = '0; mdlIer = '0; mdlEdge = '0; mdlIsr = '0;
      mdlRdata = '0;
      cyc = 0;
      hist.delete();
    end else begin
      cyc++;
      hist.push_back(inPort);
      syncNow  = sampleAt(cyc - S);
      syncPrev = sampleAt(cyc - S - 1);
      setMask  = '0;
      if (cyc >= S + 2) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (!mdlModer[i]) begin
            if (mdlEdge[i] ? (syncPrev[i] && !syncNow[i]) : (!syncPrev[i] && syncNow[i]))
              setMask[i] = 1'b1;
          end
        end
      end
      clrMask = '0;
      if (PSEL && PENABLE && accessCycle) begin
        if (PWRITE) begin
          case (PADDR[4:2])
            3'd0: mdlModer = PWDATA[7:0];
            3'd2: mdlOdr   = PWDATA[7:0];
            3'd3: mdlIer   = PWDATA[7:0];
            3'd4: mdlEdge  = PWDATA[7:0];
            3'd5: clrMask  = PWDATA[7:0];
`ifdef GPIO_BSRR_EN
            3'd6: mdlOdr   = mdlOdr | PWDATA[7:0];
            3'd7: mdlOdr   = mdlOdr & ~PWDATA[7:0];
`endif
            default: ;
          endcase
        end else begin
          case (PADDR[4:2])
            3'd0:    mdlRdata = {24'h0, mdlModer};
            3'd1:    mdlRdata = {24'h0, (syncNow & ~mdlModer) | (mdlOdr & mdlModer)};
            3'd2:    mdlRdata = {24'h0, mdlOdr};
            3'd3:    mdlRdata = {24'h0, mdlIer};
            3'd4:    mdlRdata = {24'h0, mdlEdge};
            3'd5:    mdlRdata = {24'h0, mdlIsr};
            default: mdlRdata = 32'h0;
          endcase
        end
      end
      mdlIsr = (mdlIsr & ~clrMask) | setMask;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic apbXfer(input logic wr, input logic [2:0] off, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {off, 2'b00}; PWDATA = wdata;
    accessCycle = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; accessCycle = 1'b1;
    checkOutput("pready_setup", {31'h0, PREADY}, 32'h0);
    @(posedge PCLK); #1;
    accessCycle = 1'b0;
    checkOutput("pready_access", {31'h0, PREADY}, 32'h1);
    rdata = PRDATA;
    if (!wr) checkOutput($sformatf("prdata_off%0d", off), PRDATA, mdlRdata);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    checkOutput("pready_done", {31'h0, PREADY}, 32'h0);
  endtask

  task automatic apbWrite(input logic [2:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    apbXfer(1'b1, off, data, dummy);
  endtask

  task automatic apbRead(input logic [2:0] off, output logic [31:0] data);
    apbXfer(1'b0, off, 32'h0, data);
  endtask

  task automatic checkPins();
    checkOutput("outEn", {24'h0, outEn}, {24'h0, mdlModer});
    checkOutput("outPort", {24'h0, outPort}, {24'h0, mdlOdr & mdlModer});
    checkOutput("irq", {31'h0, irq}, {31'h0, |(mdlIsr & mdlIer)});
  endtask

  task automatic applyStimulus();
    int op;
    logic [31:0] rd;
    op = $urandom_range(0, 9);
    if (op < 3) begin
      inPort = WIDTH'($urandom);
      idle($urandom_range(0, 3));
    end else if (op < 6) begin
      apbWrite(3'($urandom_range(0, 7)), $urandom);
    end else begin
      apbRead(3'($urandom_range(0, 7)), rd);
    end
    checkPins();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] rd;

    // Reset with all pins high, then confirm nothing fires once released.
    inPort  = 8'hFF;
    PRESETn = 1'b0;
    idle(3);
    checkOutput("rst_outEn", {24'h0, outEn}, 32'h0);
    checkOutput("rst_outPort", {24'h0, outPort}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("rst_pready", {31'h0, PREADY}, 32'h0);
    checkOutput("rst_prdata", PRDATA, 32'h0);
    PRESETn = 1'b1;
    idle(10);
    for (int off = 0; off < 8; off++) apbRead(3'(off), rd);
    apbRead(3'd1, rd);
    checkOutput("idr_after_reset", rd, 32'hFF);
    apbRead(3'd5, rd);
    checkOutput("isr_after_reset", rd, 32'h0);
    checkOutput("irq_after_reset", {31'h0, irq}, 32'h0);

    // Direction and output data.
    apbWrite(3'd0, 32'h0F);
    apbWrite(3'd2, 32'hA5);
    checkPins();
    checkOutput("outEn_0F", {24'h0, outEn}, 32'h0F);
    checkOutput("outPort_05", {24'h0, outPort}, 32'h05);
    apbRead(3'd1, rd);
    checkOutput("idr_low_nibble", rd & 32'hF, 32'h5);

    // Rising edge on pin 4 reaches ISR/irq after S+1 edges; W1C then clears it.
    apbWrite(3'd3, 32'h10);
    apbWrite(3'd4, 32'h00);
    inPort[4] = 1'b0;
    idle(5);
    apbRead(3'd5, rd);
    checkOutput("isr_no_fall_on_rise_mode", rd, 32'h0);
    inPort[4] = 1'b1;
    idle(S);
    checkOutput("irq_before_latency", {31'h0, irq}, 32'h0);
    idle(1);
    checkOutput("irq_at_latency", {31'h0, irq}, 32'h1);
    checkPins();
    apbRead(3'd5, rd);
    checkOutput("isr_rise4", rd, 32'h10);
    apbWrite(3'd5, 32'h10);
    checkPins();
    apbRead(3'd5, rd);
    checkOutput("isr_cleared", rd, 32'h0);
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);

    // Falling edge on pin 5 detected on the very edge its clear commits.
    apbWrite(3'd4, 32'h20);
    inPort[5] = 1'b0;
    @(posedge PCLK); #1;
    apbWrite(3'd5, 32'h20);
    apbRead(3'd5, rd);
    checkOutput("isr_set_beats_clear", rd, 32'h20);
    inPort[5] = 1'b1;
    idle(5);
    apbRead(3'd5, rd);
    checkOutput("isr_rise_ignored_in_fall_mode", rd, 32'h20);

    // Output-mode pin toggling must not raise status.
    for (int i = 0; i < 4; i++) begin
      inPort[0] = ~inPort[0];
      idle(2);
    end
    idle(4);
    apbRead(3'd5, rd);
    checkOutput("isr_bit0_masked", rd & 32'h1, 32'h0);
    apbWrite(3'd3, 32'h11);
    checkPins();
    checkOutput("irq_output_pin", {31'h0, irq}, 32'h0);

    // Atomic set/clear registers.
    apbWrite(3'd2, 32'h0F);
    apbWrite(3'd6, 32'h30);
    apbWrite(3'd7, 32'h01);
    apbRead(3'd2, rd);
`ifdef GPIO_BSRR_EN
    checkOutput("odr_bsrr", rd, 32'h3E);
`else
    checkOutput("odr_no_bsrr", rd, 32'h0F);
`endif
    apbRead(3'd6, rd);
    apbRead(3'd7, rd);
    checkPins();

    for (int it = 0; it < 200; it++) applyStimulus();
    for (int off = 0; off < 8; off++) apbRead(3'(off), rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
Parametrised APB3 GPIO peripheral and the successor to the fixed 8-bit input-only port. Each pin is individually configurable as input or output. Inputs are synchronised and can raise per-pin edge-triggered interrupts, collected into a single level irq. The block sits on the APB bus beside the existing peripherals, and its pins go to the top-level pads.

Parameters:
WIDTH, 8, number of GPIO pins (1..32); register bits at or above WIDTH read 0 and ignore writes
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (2..4)

Ports:
PCLK  in  1  APB clock; the only clock
PRESETn  in  1  asynchronous, active-low reset
PADDR  in  5  byte address; word select is PADDR[4:2]
PWDATA  in  32  write data
PWRITE  in  1  1 = write, 0 = read
PENABLE  in  1  APB access phase
PSEL  in  1  slave select
PRDATA  out  32  read data, valid while PREADY=1
PREADY  out  1  transfer complete
inPort  in  WIDTH  pad inputs (asynchronous)
outPort  out  WIDTH  pad output values
outEn  out  WIDTH  pad output enable, 1 = drive
irq  out  1  interrupt request, active high

Behaviour:
- Reset (PRESETn=0, asynchronous): all registers, PRDATA, PREADY, irq, outPort, outEn, synchroniser and edge-history flops go to 0.
- Register map (PADDR[4:2]):
  - 0 MODER: RW; 1 = output.
  - 1 IDR: RO; bit = synchronised pin if input, ODR bit if output.
  - 2 ODR: RW.
  - 3 IER: RW; interrupt enable.
  - 4 EDGE: RW; 0 = rising, 1 = falling.
  - 5 ISR: read status; write-1-to-clear.
  - 6, 7: read 0; writes ignored.
- Handshake (one wait state):
  - Cycle N: PSEL & PENABLE & ~PREADY. At that edge the write is committed or PRDATA is loaded, and PREADY <= 1.
  - Cycle N+1: PREADY=1, transfer completes; at that edge PREADY <= 0.
  - PRDATA holds its value outside read transfers.
  - PSEL dropped mid-transfer: PREADY <= 0 and nothing further is committed.
- Outputs:
  - outEn = MODER; outPort = ODR & MODER. Both are registered-equivalent and change on the edge after the committing write.
- Synchroniser:
  - inPort passes through SYNC_STAGES flops into sync.
  - prev <= sync every cycle.
- Edge detect arming:
  - A settle counter runs from reset release. Detection is disabled until SYNC_STAGES+1 cycles have elapsed.
  - Consequence: a pin held high through reset raises no interrupt.
- Edge detect, per bit i (input mode only; MODER[i]=1 masks detection):
  - rise = sync & ~prev; fall = ~sync & prev.
  - ISR[i] sets on the edge selected by EDGE[i].
  - Detection is independent of IER. IER gates irq only.
- Latency: pin transition to ISR set is SYNC_STAGES+1 cycles; irq follows in the same cycle.
- ISR clear: ISR write with data bit 1 clears that bit. If a new edge on the same cycle as the clear, set wins and the bit stays 1.
- irq = |(ISR & IER), combinational from registers, so glitch-free.
- Changing EDGE or MODER does not alter ISR bits that are already set.

Optional Feature:
Macro: GPIO_BSRR_EN.
- Defined: offset 5 ISR is unchanged, and two write-only atomic registers are added:
  - offset 6 BSR: bits written 1 set the corresponding ODR bits.
  - offset 7 BRR: bits written 1 clear the corresponding ODR bits.
  - Both read 0.
- Not defined: offsets 6 and 7 are unmapped (read 0, write ignored), and no atomic set/clear logic exists.

Test Plan:
- Reset with inPort=8'hFF held, release, wait 10 cycles -> all reads 0 except IDR=8'hFF; ISR=0; irq=0.
- Write MODER=8'h0F, ODR=8'hA5 -> outEn=8'h0F, outPort=8'h05; IDR low nibble reads 4'h5; each transfer shows PREADY high for exactly 1 cycle, one cycle after PENABLE.
- IER=8'h10, EDGE=0, drive inPort[4] 0->1 -> ISR=8'h10 and irq=1 after 3 cycles (SYNC_STAGES=2); write ISR=8'h10 -> ISR=0, irq=0.
- EDGE[5]=1, pulse inPort[5] 1->0 on the same cycle the ISR=8'h20 clear commits -> ISR[5] stays 1.
- Toggle inPort[0] with MODER[0]=1 -> ISR[0] stays 0; set IER bit 0 -> irq stays 0.
- With GPIO_BSRR_EN, ODR=8'h0F, write BSR=8'h30 then BRR=8'h01 -> ODR reads 8'h3E. Without the macro, the same writes leave ODR=8'h0F.
